// File: rtl/cnn_mac_pipe_dsp_pkg.sv
// Shared definitions for the CNN MAC datapath: width checks, round/saturate
// helper and the result-format defaults also used by the dense layer.
package cnn_mac_pkg;

  localparam int CNN_FRAC_SHIFT = 6;
  localparam int CNN_OUT_WIDTH  = 16;
  localparam int CNN_CALC_W     = 64;

  typedef struct packed {
    logic signed [CNN_CALC_W-1:0] data;
    logic                         sat;
  } rnd_sat_t;

  // The accumulator must hold a full product and fit the 64-bit rounding path.
  function automatic bit acc_width_ok(input int a_w, input int b_w, input int acc_w);
    return (acc_w >= a_w + b_w) && (acc_w < CNN_CALC_W);
  endfunction

  function automatic rnd_sat_t round_sat(input logic signed [CNN_CALC_W-1:0] acc,
                                         input int shift, input int out_w);
    logic signed [CNN_CALC_W-1:0] v;
    logic signed [CNN_CALC_W-1:0] hi;
    logic signed [CNN_CALC_W-1:0] lo;
    rnd_sat_t res;
    v = acc;
    if (shift > 0) v = v + (64'sd1 <<< (shift - 1));
    v  = v >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    res.sat = 1'b1;
    if (v > hi)      res.data = hi;
    else if (v < lo) res.data = lo;
    else begin
      res.data = v;
      res.sat  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/cnn_mac_pipe_dsp_if.sv
// Operand/result handshake bundle between the conv/dense loops, the MAC and the output buffer.
interface cnn_mac_pipe_dsp_if #(
  parameter int A_WIDTH   = 14,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_last;
  logic signed [A_WIDTH-1:0]   a;
  logic signed [B_WIDTH-1:0]   b;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_sat;
  logic [CNT_WIDTH-1:0]        out_count;

  modport master (
    output in_valid, in_last, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_last, a, b, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_count
  );
endinterface

// File: rtl/cnn_mac_pipe_dsp_mul_pipe.sv
// Signed multiplier with input register and NUM_STAGE valid/last-tagged product
// registers on one shared enable, laid out to fold into DSP48 A/B, M and P registers.
module cnn_mac_mul_pipe #(
  parameter int A_WIDTH   = 14,
  parameter int B_WIDTH   = 8,
  parameter int NUM_STAGE = 2,
  localparam int P_WIDTH  = A_WIDTH + B_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic                      i_vld,
  input  logic                      i_last,
  input  logic signed [A_WIDTH-1:0] i_a,
  input  logic signed [B_WIDTH-1:0] i_b,
  output logic                      o_vld,
  output logic                      o_last,
  output logic signed [P_WIDTH-1:0] o_p
);
  logic signed [A_WIDTH-1:0] r_a_p0;
  logic signed [B_WIDTH-1:0] r_b_p0;
  logic                      r_vld_p0;
  logic                      r_last_p0;
  logic signed [P_WIDTH-1:0] r_p_pn [NUM_STAGE];
  logic [NUM_STAGE-1:0]      r_vld_pn;
  logic [NUM_STAGE-1:0]      r_last_pn;
  logic signed [P_WIDTH-1:0] w_prod;

  assign w_prod = r_a_p0 * r_b_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_pn <= '0;
    end else if (i_en) begin
      r_vld_p0    <= i_vld;
      r_vld_pn[0] <= r_vld_p0;
      for (int i = 1; i < NUM_STAGE; i++) r_vld_pn[i] <= r_vld_pn[i-1];
    end
  end

  // p0: operand registers; p1..pN: product registers
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_a_p0       <= i_a;
      r_b_p0       <= i_b;
      r_last_p0    <= i_last;
      r_p_pn[0]    <= w_prod;
      r_last_pn[0] <= r_last_p0;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_p_pn[i]    <= r_p_pn[i-1];
        r_last_pn[i] <= r_last_pn[i-1];
      end
    end
  end

  assign o_vld  = r_vld_pn[NUM_STAGE-1];
  assign o_last = r_last_pn[NUM_STAGE-1];
  assign o_p    = r_p_pn[NUM_STAGE-1];
endmodule

// File: rtl/cnn_mac_pipe_dsp.sv
// Pipelined signed MAC: one dot product per last-terminated beat sequence,
// rounded half-up, shifted and saturated, with global-stall backpressure.
module cnn_mac_pipe_dsp
  import cnn_mac_pkg::*;
#(
  parameter int A_WIDTH    = 14,
  parameter int B_WIDTH    = 8,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_SHIFT = CNN_FRAC_SHIFT,
  parameter int OUT_WIDTH  = CNN_OUT_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input logic              ap_clk,
  input logic              ap_rst,
  cnn_mac_pipe_dsp_if.slave bus
);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  if (!acc_width_ok(A_WIDTH, B_WIDTH, ACC_WIDTH)) begin : g_bad_acc
    $error("ACC_WIDTH must be >= A_WIDTH+B_WIDTH and < 64");
  end
  if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_stage
    $error("NUM_STAGE must be in 1..4");
  end
  if (FRAC_SHIFT < 0 || FRAC_SHIFT >= ACC_WIDTH) begin : g_bad_shift
    $error("FRAC_SHIFT must be in 0..ACC_WIDTH-1");
  end

  logic                        w_stall;
  logic                        w_en;
  logic                        w_m_vld;
  logic                        w_m_last;
  logic signed [P_WIDTH-1:0]   w_m_p;
  logic signed [ACC_WIDTH-1:0] w_p_ext;
  logic signed [63:0]          w_acc64;
  rnd_sat_t                    w_rs;
  logic                        w_unused_hi;

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic                        r_first;
  logic                        r_fin;
  logic                        r_out_vld;
  logic signed [OUT_WIDTH-1:0] r_out_data;
  logic                        r_out_sat;
  logic [CNT_WIDTH-1:0]        r_out_cnt;

  assign w_stall      = r_out_vld & ~bus.out_ready;
  assign w_en         = ~w_stall;
  assign bus.in_ready = w_en;

  cnn_mac_mul_pipe #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .NUM_STAGE(NUM_STAGE)
  ) u_mul (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .i_en  (w_en),
    .i_vld (bus.in_valid & w_en),
    .i_last(bus.in_last),
    .i_a   (bus.a),
    .i_b   (bus.b),
    .o_vld (w_m_vld),
    .o_last(w_m_last),
    .o_p   (w_m_p)
  );

  assign w_p_ext     = ACC_WIDTH'(w_m_p);
  assign w_acc64     = 64'(r_acc);
  assign w_rs        = round_sat(w_acc64, FRAC_SHIFT, OUT_WIDTH);
  assign w_unused_hi = ^w_rs.data[63:OUT_WIDTH];

  // accumulate stage: r_fin marks that r_acc/r_cnt now hold a finished dot product
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b1;
      r_fin   <= 1'b0;
    end else if (w_en) begin
      r_fin <= w_m_vld & w_m_last;
      if (w_m_vld) begin
        if (r_first) begin
          r_acc <= w_p_ext;
          r_cnt <= CNT_WIDTH'(1);
        end else begin
          r_acc <= r_acc + w_p_ext;
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        r_first <= w_m_last;
      end
    end
  end

  // output stage
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      r_out_cnt  <= '0;
    end else if (w_en) begin
      r_out_vld <= r_fin;
      if (r_fin) begin
        r_out_data <= w_rs.data[OUT_WIDTH-1:0];
        r_out_sat  <= w_rs.sat;
        r_out_cnt  <= r_cnt;
      end
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_count = r_out_cnt;
endmodule
